// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register that feeds memory_cycle.
module execute_cycle #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  ALUSrcE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic [2:0]            ALUControlE,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [XLEN-1:0]       ResultW,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       ALU_ResultM
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_RSV6 = 3'b110,
    ALU_RSV7 = 3'b111
  } aluOp_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_RSV  = 2'b11
  } fwdSel_e;

  aluOp_e          aluOp;
  fwdSel_e         fwdSelA;
  fwdSel_e         fwdSelB;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;
  logic            signedLess;
  logic            zeroE;

  assign aluOp   = aluOp_e'(ALUControlE);
  assign fwdSelA = fwdSel_e'(ForwardA_E);
  assign fwdSelB = fwdSel_e'(ForwardB_E);

  // The MEM-stage source is the registered ALU_ResultM, never the live ALU
  // output, so forwarding cannot close a combinational loop.
  always_comb begin
    unique case (fwdSelA)
      FWD_WB:  srcA = ResultW;
      FWD_MEM: srcA = ALU_ResultM;
      default: srcA = RD1_E;
    endcase
  end

  always_comb begin
    unique case (fwdSelB)
      FWD_WB:  fwdB = ResultW;
      FWD_MEM: fwdB = ALU_ResultM;
      default: fwdB = RD2_E;
    endcase
  end

  assign srcB       = ALUSrcE ? Imm_Ext_E : fwdB;
  assign signedLess = $signed(srcA) < $signed(srcB);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    aluResult = '0;
    unique case (aluOp)
      ALU_ADD: aluResult = srcA + srcB;
      ALU_SUB: aluResult = srcA - srcB;
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_XOR: aluResult = srcA ^ srcB;
      ALU_SLT: aluResult = {{(XLEN-1){1'b0}}, signedLess};
      default: aluResult = '0;
    endcase
  end

  assign zeroE     = (aluResult == '0);
  assign PCSrcE    = (zeroE & BranchE) | JumpE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // Store data is the forwarded rs2 value, independent of ALUSrcE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwdB;
      ALU_ResultM <= aluResult;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle: reset, ALU ops, store path,
// forwarding, branch resolution and mid-stream reset.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE, ForwardA_E, ForwardB_E;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int assertCount = 0;
  int failCount   = 0;

  execute_cycle #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0;
    BranchE = 0; JumpE = 0; ALUControlE = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 0; ForwardB_E = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; ALUSrcE = 0;
    BranchE = 0; JumpE = 0; ALUControlE = 3'b000;
    RD1_E = 32'h11; RD2_E = 32'h22; Imm_Ext_E = 32'h33; RD_E = 5'd9;
    PCE = 32'h40; PCPlus4E = 32'h44; ResultW = 32'h55; ForwardA_E = 0; ForwardB_E = 0;
    #6;
    assertCount++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== 9'd0) begin
      failCount++;
      $display("FAIL reset_ctrl: got %b, expected 0", {RegWriteM, MemWriteM, ResultSrcM, RD_M});
    end
    assertCount++;
    if (ALU_ResultM !== 32'h0) begin
      failCount++; $display("FAIL reset_alu: got %h, expected 0", ALU_ResultM);
    end
    assertCount++;
    if (WriteDataM !== 32'h0 || PCPlus4M !== 32'h0) begin
      failCount++;
      $display("FAIL reset_data: got wd=%h pc4=%h, expected 0", WriteDataM, PCPlus4M);
    end
    #1;
    rst = 1;
    clear_inputs();
    RD1_E = 5; RD2_E = 3; ALUControlE = 3'b000; RD_E = 5'd5; RegWriteE = 1;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'd8) begin
      failCount++; $display("FAIL first_alu: got %h, expected 8", ALU_ResultM);
    end
    assertCount++;
    if (RD_M !== 5'd5 || RegWriteM !== 1'b1) begin
      failCount++; $display("FAIL first_ctrl: got rd=%0d rw=%b, expected 5/1", RD_M, RegWriteM);
    end
  endtask

  logic [2:0]  swOp  [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b000, 3'b110};
  logic [31:0] swA   [8] = '{32'hF, 32'hF, 32'hF, 32'hF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'hF};
  logic [31:0] swB   [8] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h3};
  logic [31:0] swExp [8] = '{32'hC, 32'h3, 32'hF, 32'hC, 32'h1, 32'h0, 32'h0, 32'h0};

  task automatic test_alu;
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      ALUControlE = swOp[i]; RD1_E = swA[i]; RD2_E = swB[i];
      step();
      assertCount++;
      if (ALU_ResultM !== swExp[i]) begin
        failCount++;
        $display("FAIL alu_%0d op=%b: got %h, expected %h", i, swOp[i], ALU_ResultM, swExp[i]);
      end
    end
  endtask

  task automatic test_imm_store;
    clear_inputs();
    ALUSrcE = 1; Imm_Ext_E = 32'h66; RD1_E = 0; RD2_E = 32'h67; MemWriteE = 1;
    ResultSrcE = 2'b01; PCPlus4E = 32'h204;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h66) begin
      failCount++; $display("FAIL store_addr: got %h, expected 66", ALU_ResultM);
    end
    assertCount++;
    if (WriteDataM !== 32'h67) begin
      failCount++; $display("FAIL store_data: got %h, expected 67", WriteDataM);
    end
    assertCount++;
    if (MemWriteM !== 1'b1 || ResultSrcM !== 2'b01 || PCPlus4M !== 32'h204) begin
      failCount++;
      $display("FAIL store_ctrl: got mw=%b rs=%b pc4=%h, expected 1/01/204",
               MemWriteM, ResultSrcM, PCPlus4M);
    end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    RD1_E = 32'h10; ALUControlE = 3'b000;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h10) begin
      failCount++; $display("FAIL fwd_setup: got %h, expected 10", ALU_ResultM);
    end
    clear_inputs();
    ForwardA_E = 2'b10; RD1_E = 32'hDEAD; Imm_Ext_E = 4; ALUSrcE = 1;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h14) begin
      failCount++; $display("FAIL fwd_a_mem: got %h, expected 14", ALU_ResultM);
    end
    clear_inputs();
    ForwardB_E = 2'b01; ResultW = 32'h55; RD2_E = 32'h99; RD1_E = 32'h100;
    ALUSrcE = 1; Imm_Ext_E = 8; MemWriteE = 1;
    step();
    assertCount++;
    if (WriteDataM !== 32'h55 || ALU_ResultM !== 32'h108) begin
      failCount++;
      $display("FAIL fwd_b_wb: got wd=%h alu=%h, expected 55/108", WriteDataM, ALU_ResultM);
    end
    clear_inputs();
    ForwardA_E = 2'b01; ResultW = 32'h55; RD1_E = 32'h1; ALUSrcE = 1; Imm_Ext_E = 1;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h56) begin
      failCount++; $display("FAIL fwd_a_wb: got %h, expected 56", ALU_ResultM);
    end
    clear_inputs();
    ForwardA_E = 2'b11; ForwardB_E = 2'b10; RD1_E = 32'h7; RD2_E = 32'h1; ResultW = 32'h77;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h5D || WriteDataM !== 32'h56) begin
      failCount++;
      $display("FAIL fwd_rsv_mem: got alu=%h wd=%h, expected 5d/56", ALU_ResultM, WriteDataM);
    end
  endtask

  task automatic test_branch;
    clear_inputs();
    PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF0; RD1_E = 7; RD2_E = 7;
    ALUControlE = 3'b001; BranchE = 1;
    #1;
    assertCount++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF0) begin
      failCount++;
      $display("FAIL beq_taken: got src=%b tgt=%h, expected 1/f0", PCSrcE, PCTargetE);
    end
    RD2_E = 8;
    #1;
    assertCount++;
    if (PCSrcE !== 1'b0) begin
      failCount++; $display("FAIL beq_not_taken: got %b, expected 0", PCSrcE);
    end
    JumpE = 1;
    #1;
    assertCount++;
    if (PCSrcE !== 1'b1) begin
      failCount++; $display("FAIL jal: got %b, expected 1", PCSrcE);
    end
    RD2_E = 7;
    #1;
    assertCount++;
    if (PCSrcE !== 1'b1) begin
      failCount++; $display("FAIL branch_and_jump: got %b, expected 1", PCSrcE);
    end
    BranchE = 0; JumpE = 0;
    #1;
    assertCount++;
    if (PCSrcE !== 1'b0) begin
      failCount++; $display("FAIL zero_no_branch: got %b, expected 0", PCSrcE);
    end
    step();
  endtask

  task automatic test_reset_midstream;
    clear_inputs();
    RD1_E = 32'h10; Imm_Ext_E = 4; ALUSrcE = 1; RegWriteE = 1; RD_E = 5'd3;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h14 || RD_M !== 5'd3) begin
      failCount++; $display("FAIL mid_setup: got alu=%h rd=%0d, expected 14/3", ALU_ResultM, RD_M);
    end
    #2;
    rst = 0;
    PCE = 32'h200; Imm_Ext_E = 32'h10;
    #1;
    assertCount++;
    if (ALU_ResultM !== 32'h0 || RD_M !== 5'd0 || RegWriteM !== 1'b0) begin
      failCount++;
      $display("FAIL mid_async_clear: got alu=%h rd=%0d rw=%b, expected 0", ALU_ResultM, RD_M, RegWriteM);
    end
    assertCount++;
    if (PCTargetE !== 32'h210) begin
      failCount++; $display("FAIL mid_target: got %h, expected 210", PCTargetE);
    end
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h0 || RegWriteM !== 1'b0) begin
      failCount++; $display("FAIL mid_hold: got alu=%h rw=%b, expected 0", ALU_ResultM, RegWriteM);
    end
    #2;
    rst = 1;
    clear_inputs();
    RD1_E = 32'h30; RD2_E = 32'h5; ALUControlE = 3'b001; RegWriteE = 1; RD_E = 5'd7;
    step();
    assertCount++;
    if (ALU_ResultM !== 32'h2B || RD_M !== 5'd7 || RegWriteM !== 1'b1) begin
      failCount++;
      $display("FAIL mid_release: got alu=%h rd=%0d rw=%b, expected 2b/7/1", ALU_ResultM, RD_M, RegWriteM);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_imm_store();
    test_forwarding();
    test_branch();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- EX stage of the 5-stage RV32I pipeline: forwarding muxes, ALU, branch/jump resolution, PC target adder.
- Holds the EX/MEM pipeline register that feeds memory_cycle.
- Registered outputs connect port-for-port to memory_cycle inputs.
- Branch decision (PCSrcE, PCTargetE) is combinational back to fetch.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register-index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteE  in  1  register-file write enable from decode
- MemWriteE  in  1  data-memory write enable
- ResultSrcE  in  2  writeback select (00 ALU, 01 mem, 10 PC+4)
- ALUSrcE  in  1  0: SrcB = forwarded RD2; 1: SrcB = Imm_Ext_E
- BranchE  in  1  beq instruction
- JumpE  in  1  jal instruction
- ALUControlE  in  3  ALU opcode
- RD1_E  in  XLEN  rs1 data
- RD2_E  in  XLEN  rs2 data
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  REG_ADDR_W  destination register
- PCE  in  XLEN  instruction PC
- PCPlus4E  in  XLEN  PC+4
- ResultW  in  XLEN  writeback result, forwarding source
- ForwardA_E  in  2  SrcA select (00 RD1_E, 01 ResultW, 10 ALU_ResultM)
- ForwardB_E  in  2  same encoding, for rs2 path
- PCSrcE  out  1  redirect fetch
- PCTargetE  out  XLEN  PCE + Imm_Ext_E
- RegWriteM, MemWriteM  out  1  registered control
- ResultSrcM  out  2  registered
- RD_M  out  REG_ADDR_W  registered
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN  registered

Behaviour:
- Reset: rst low asserts immediately, independent of clk. All M-side outputs clear to 0 and hold while rst is low. The first capture is the first rising edge after rst goes high.
- Forwarding:
  - SrcA = mux(ForwardA_E): 00 RD1_E, 01 ResultW, 10 ALU_ResultM (this block's own registered output). Select 11 yields RD1_E.
  - Forwarded B (fB) uses the same rule on RD2_E with ForwardB_E.
  - SrcB = ALUSrcE ? Imm_Ext_E : fB.
- ALU (combinational; XLEN-bit; wrap-around, no overflow flag):
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt, signed: result is 1 if SrcA < SrcB, else 0
  - 110, 111 yield 0
- Zero = (ALU result == 0).
- Branch/jump:
  - PCSrcE = (Zero & BranchE) | JumpE.
  - PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
  - Both are combinational, same cycle as the E inputs.
- Pipeline register (1-cycle latency), on each rising edge with rst high:
  - RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M take their E values.
  - ALU_ResultM takes the ALU result.
  - WriteDataM takes fB. It is never Imm_Ext_E, even when ALUSrcE=1.
- No stall or flush inputs. Bubbles are inserted upstream by zeroing the control inputs.
- Back-to-back dependency: ForwardA_E=10 selects the value already in ALU_ResultM, i.e. the previous instruction's result. No combinational loop is allowed: the source is the register output.
- BranchE and JumpE both high: PCSrcE=1.
- Reset asserted mid-stream: in-flight M contents are lost and outputs read 0. PCSrcE/PCTargetE still follow the E inputs combinationally.

Test Plan:
- Reset: hold rst=0 for 7 ns with E inputs driven nonzero -> all M outputs 0. Release; first edge: RD1_E=5, RD2_E=3, ALUControlE=000, RD_E=5, RegWriteE=1 -> ALU_ResultM=8, RD_M=5, RegWriteM=1.
- ALU sweep with ALUSrcE=0, SrcA=0x0000000F, SrcB=0x00000003, one edge later each:
  - sub -> 0x0000000C
  - and -> 0x3
  - or -> 0xF
  - xor -> 0xC
  - slt with SrcA=0xFFFFFFFF, SrcB=1 -> 1
  - add 0xFFFFFFFF+1 -> 0
- Immediate/store: ALUSrcE=1, Imm_Ext_E=0x66, RD1_E=0, RD2_E=0x67, MemWriteE=1 -> ALU_ResultM=0x66, WriteDataM=0x67, MemWriteM=1.
- Forwarding:
  - Cycle 1: result 0x10 is registered in ALU_ResultM.
  - Cycle 2: ForwardA_E=10, RD1_E=0xDEAD, Imm=4, ALUSrcE=1, add -> ALU_ResultM=0x14.
  - Repeat with ForwardB_E=01, ResultW=0x55, store -> WriteDataM=0x55.
- Branch: PCE=0x100, Imm_Ext_E=0xFFFFFFF0, RD1_E=RD2_E=7, sub, BranchE=1 -> PCSrcE=1, PCTargetE=0xF0 same cycle. With RD2_E=8 -> PCSrcE=0. With JumpE=1 -> PCSrcE=1.
- Reset mid-stream: assert rst low between clock edges while ALU_ResultM=0x14 -> outputs 0 immediately, before the next edge. Release; the next edge captures the current E inputs normally.
